// File: rtl/usb_in_arbiter.sv
// Round-robin arbiter sharing the USB CDC IN byte stream between NUM_REQ requesters.
// Grants last a whole message; a grant is revoked if the owner stalls for TIMEOUT cycles.
module usb_in_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [7:0]           in_data_o,
  output logic                 in_valid_o,
  input  logic                 in_ready_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 busy_o,
  output logic                 timeout_o
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t               r_state;
  logic [IW-1:0]        r_g;
  logic [IW-1:0]        r_last_grant;
  logic [CW-1:0]        r_cnt;
  logic [NUM_REQ-1:0]   r_grant;

  logic                 w_valid_g;
  logic                 w_last_g;
  logic                 w_xfer;
  logic                 w_timeout;
  logic                 w_found;
  logic [IW-1:0]        w_pick;

  // Handshake: a byte moves when valid and ready are both high in the same cycle;
  // the granted requester's valid/data/last pass straight to the core and in_ready_i
  // returns only to that requester. Non-granted requesters always see ready low.
  assign w_valid_g = req_valid_i[r_g];
  assign w_last_g  = req_last_i[r_g];
  assign w_xfer    = (r_state == S_GRANT) && w_valid_g && in_ready_i;
  assign w_timeout = (r_state == S_GRANT) && !w_valid_g && (r_cnt == CW'(TIMEOUT - 1));

  // First valid requester searching upward from the one after the last owner.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!w_found && req_valid_i[(int'(r_last_grant) + i) % NUM_REQ]) begin
        w_found = 1'b1;
        w_pick  = IW'((int'(r_last_grant) + i) % NUM_REQ);
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    in_data_o   = '0;
    in_valid_o  = 1'b0;
    if (r_state == S_GRANT) begin
      in_data_o        = req_data_i[{r_g, 3'b000} +: 8];
      in_valid_o       = w_valid_g;
      req_ready_o[r_g] = in_ready_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state      <= S_IDLE;
      r_g          <= '0;
      r_last_grant <= IW'(NUM_REQ - 1);
      r_cnt        <= '0;
      r_grant      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_found) begin
            r_g     <= w_pick;
            r_grant <= NUM_REQ'(1) << w_pick;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (w_xfer) begin
            r_cnt <= '0;
            if (w_last_g) begin
              r_state      <= S_IDLE;
              r_last_grant <= r_g;
              r_grant      <= '0;
            end
          end else if (w_valid_g) begin
            // Core backpressure never counts toward the stall timeout.
            r_cnt <= '0;
          end else if (w_timeout) begin
            r_state      <= S_IDLE;
            r_last_grant <= r_g;
            r_grant      <= '0;
            r_cnt        <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant_o   = r_grant;
  assign busy_o    = (r_state == S_GRANT);
  assign timeout_o = w_timeout;

endmodule
